// File: rtl/node_accum.sv
// Per-node path-count accumulator: sums matching filtered arrivals, then emits one request per successor.
// Cfg or last arrival to first request: 1 cycle; a request holds stable while i_req_rdy is low.
module node_accum #(
  parameter  int PAYLOAD_WIDTH = 16,
  parameter  int MAX_OUT       = 8,
  parameter  int INDEG_W       = 8,
  localparam int OUTDEG_W      = $clog2(MAX_OUT + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cfg_vld,
  input  logic [11:0]               i_cfg_node,
  input  logic                      i_cfg_src,
  input  logic [INDEG_W-1:0]        i_cfg_indeg,
  input  logic [OUTDEG_W-1:0]       i_cfg_outdeg,
  input  logic [12*MAX_OUT-1:0]     i_cfg_succ,
  output logic [11:0]               o_target_node,
  input  logic                      i_filt_vld,
  input  logic [PAYLOAD_WIDTH-1:0]  i_filt_paths,
  input  logic [11:0]               i_filt_nodenum,
  output logic                      o_req_vld,
  input  logic                      i_req_rdy,
  output logic [PAYLOAD_WIDTH-1:0]  o_req_paths,
  output logic [11:0]               o_req_nodenum,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [PAYLOAD_WIDTH-1:0]  o_result,
  output logic                      o_ovf,
  output logic                      o_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state;
  logic [11:0]              node_q;
  logic [INDEG_W-1:0]       indeg_q;
  logic [OUTDEG_W-1:0]      outdeg_q;
  logic [12*MAX_OUT-1:0]    succ_q;
  logic [PAYLOAD_WIDTH-1:0] acc;
  logic [INDEG_W-1:0]       cnt;
  logic [OUTDEG_W-1:0]      idx;
  logic                     ovf_q;
  logic                     err_q;

  logic                     arrival;
  logic [PAYLOAD_WIDTH:0]   acc_sum;
  logic [INDEG_W-1:0]       cnt_inc;
  logic [11:0]              succ_sel;

  assign arrival = i_filt_vld && (i_filt_nodenum == node_q);
  assign acc_sum = {1'b0, acc} + {1'b0, i_filt_paths};
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    succ_sel = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (idx == OUTDEG_W'(i)) succ_sel = succ_q[i*12 +: 12];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      node_q   <= '0;
      indeg_q  <= '0;
      outdeg_q <= '0;
      succ_q   <= '0;
      acc      <= '0;
      cnt      <= '0;
      idx      <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (arrival) begin
            acc <= acc_sum[PAYLOAD_WIDTH-1:0];
            cnt <= cnt_inc;
            if (acc_sum[PAYLOAD_WIDTH]) ovf_q <= 1'b1;
            if (cnt_inc == indeg_q) state <= (outdeg_q != '0) ? S_EMIT : S_DONE;
          end
        end
        S_EMIT: begin
          if (arrival) err_q <= 1'b1;
          if (i_req_rdy) begin
            idx <= idx + 1'b1;
            if (idx == outdeg_q - 1'b1) state <= S_DONE;
          end
        end
        default: begin
          // A cfg load in the same cycle as a stray arrival wins: flags start clean.
          if (i_cfg_vld) begin
            node_q   <= i_cfg_node;
            indeg_q  <= i_cfg_indeg;
            outdeg_q <= i_cfg_outdeg;
            succ_q   <= i_cfg_succ;
            acc      <= {{(PAYLOAD_WIDTH-1){1'b0}}, i_cfg_src};
            cnt      <= '0;
            idx      <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            if (i_cfg_indeg != '0)       state <= S_ACCUM;
            else if (i_cfg_outdeg != '0) state <= S_EMIT;
            else                         state <= S_DONE;
          end else if (arrival) begin
            err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_target_node = node_q;
  assign o_req_vld     = (state == S_EMIT);
  assign o_req_paths   = (state == S_EMIT) ? acc : '0;
  assign o_req_nodenum = (state == S_EMIT) ? succ_sel : '0;
  assign o_busy        = (state == S_ACCUM) || (state == S_EMIT);
  assign o_done        = (state == S_DONE);
  assign o_result      = acc;
  assign o_ovf         = ovf_q;
  assign o_err         = err_q;

endmodule
